instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming MIPS instruction encoder: the inverse of the pipeline's control decoder. It accepts one symbolic instruction per handshake (mnemonic id plus operand fields), packs it into a 32-bit MIPS word, assigns it a sequential address, and queues the result in an internal FIFO. It drives instruction-memory preload and self-checking benches, so its field placement matches the decoder's field extraction exactly.

## Interface
- `BASE_PC`, `32'h0000_3000`: address given to the first word after reset or restart.
- `DEPTH`, `4`: number of FIFO entries; must be a power of two, at least 2.
- `clk` input 1: the only clock.
- `reset` input 1: asynchronous, active-low.
- `restart` input 1: synchronous flush; also reloads the address counter.
- `in_valid` input 1: request is valid.
- `in_ready` output 1: encoder can accept a request.
- `in_id` input 6: mnemonic id.
- `in_rs` input 5: rs operand.
- `in_rt` input 5: rt operand.
- `in_rd` input 5: rd operand.
- `in_shamt` input 5: shift amount.
- `in_imm16` input 16: immediate, used by I-type, load and store.
- `in_target` input 32: absolute byte target, used by branches and j/jal.
- `out_valid` output 1: FIFO head holds a word.
- `out_ready` input 1: consumer takes the head word.
- `out_instr` output 32: encoded word at the head.
- `out_pc` output 32: address of that word.
- `out_err` output 1: the head entry failed encoding.
- `count` output clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Id map.** Ids 0–47 in order:
  - 0–15: add addu sub subu and or xor nor slt sltu sll srl sra sllv srlv srav
  - 16–23: mult multu div divu mfhi mflo mthi mtlo
  - 24–25: jr jalr
  - 26–33: lb lh lw lbu lhu sb sh sw
  - 34–40: beq bne blez bgtz bltz bgez bltzal
  - 41–42: j jal
  - 43–47: addi addiu andi ori xori
  - Ids 48–63 are illegal.
- **Opcode and funct.** Standard MIPS32 values from the shared constants header.
- **Field rules.** Fields the instruction does not use are forced to 0.
  - R-type ALU: rs, rt, rd; shamt = `in_shamt` only for sll/srl/sra.
  - Variable shifts (sllv/srlv/srav): rs is the shift source.
  - mult group (mult/multu/div/divu): rs, rt.
  - mfhi/mflo: rd only.
  - mthi/mtlo and jr: rs only.
  - jalr: rs and rd.
  - I-type, load, store: rs, rt, imm16.
  - Branches: beq/bne take rs and rt. blez/bgtz take rs with rt = 0. bltz/bgez/bltzal take rs with rt = 0x00/0x01/0x10, opcode 1.
  - Branch offset: `(in_target - (pc+4)) >>> 2`, truncated to 16 bits.
  - j/jal: index = `in_target[27:2]`.
- **Error flag.** An entry's `err` is set on any of the following:
  - illegal id: word stored as 0x00000000;
  - branch with `in_target[1:0] != 0`, or an offset outside [-32768, 32767];
  - j/jal with `in_target[1:0] != 0`, or `in_target[31:28] != (pc+4)[31:28]`.
  - The word is still emitted, with truncated fields, and pc still advances.
- **Address counter.** `pc` advances by 4 on every accept, including error entries.
- **Accept.** A request is accepted when `in_valid & in_ready`. `in_ready = !full & !restart`.
- **Pop.** The head is removed when `out_valid & out_ready`. Order is strictly FIFO.
- **Full and empty.** When full there is no bypass: a pop in the same cycle does not let `in_ready` rise until the next cycle. When empty, the out fields hold 0.
- **Simultaneous push and pop** (not full, not empty): count unchanged.
- **Restart.** Empties the FIFO and sets pc = `BASE_PC` at the next edge. It overrides any push or pop in that cycle.
- **Wrap.** The read and write pointers wrap modulo DEPTH. pc wraps modulo 2^32.

## Timing
- **Latency.** A word accepted at edge N is on `out_instr` / `out_pc` / `out_err` with `out_valid` = 1 after edge N if the FIFO was empty. There is no combinational in→out path.
- **Outputs are registered or purely state-derived.** `in_ready` depends combinationally only on count and `restart`.
- **Reset** (asynchronous, immediate on `reset` = 0):
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `out_err` = 0, `count` = 0, `in_ready` = 1 once `reset` is released;
  - internal pc = `BASE_PC`.
  - Reset mid-stream discards all queued entries.
- **Output hold.** Head fields stay stable while `out_valid & !out_ready`.

## Test plan
- **R-type.** Reset, then addu (id 1), rs=1, rt=2, rd=3 → next cycle `out_instr` = 0x00221821, `out_pc` = 0x00003000, `out_err` = 0.
- **Branch offset.** After one filler word (pc = 0x3004), beq (id 34), rs=1, rt=2, target=0x00003000 → 0x1022FFFE. Same with target=0x00003002 → `out_err` = 1.
- **Jump and immediate.**
  - jal (id 42), target=0x00003010 → 0x0C000C04.
  - ori (id 46), rs=0, rt=5, imm=0x1234 → 0x34051234.
  - bltzal (id 40), rs=4 → rt field = 0x10, i.e. `instr[20:16]` = 5'b10000.
- **Backpressure.** DEPTH=4, `out_ready` = 0, stream 5 requests → `in_ready` falls after the 4th accept, count = 4, the 5th is held. Raise `out_ready` → words drain in order with pcs 0x3000, 0x3004, … and the 5th is then accepted.
- **Illegal id.** id 63 → 0x00000000 with `out_err` = 1; the next word's pc is still +4.
- **Flush.**
  - Pulse `restart` with 3 entries queued and `in_valid` high → count = 0, the request is dropped, and the next word has pc 0x3000.
  - Assert `reset` mid-drain → outputs zero immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Streaming MIPS instruction encoder. Each accepted request (mnemonic id plus
// operand fields) is packed into a 32-bit MIPS word. The word is tagged with a
// sequential address and an error flag, then queued in a small FIFO. Field
// placement mirrors the pipeline decoder's field extraction exactly.
//
// Parameters
//   BASE_PC      address given to the first word after reset or restart
//   DEPTH        FIFO entries (power of two, >= 2)
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   restart_i    synchronous flush, reloads the address counter
//   in_valid_i   request valid
//   in_ready_o   encoder can accept a request
//   in_id_i      mnemonic id (0..47 legal)
//   in_rs_i      rs operand
//   in_rt_i      rt operand
//   in_rd_i      rd operand
//   in_shamt_i   shift amount (sll/srl/sra only)
//   in_imm16_i   immediate for I-type, load and store
//   in_target_i  absolute byte target for branches and j/jal
//   out_valid_o  FIFO head holds a word
//   out_ready_i  consumer takes the head word
//   out_instr_o  encoded word at the head (0 when empty)
//   out_pc_o     address of the head word (0 when empty)
//   out_err_o    head entry failed encoding (0 when empty)
//   count_o      FIFO occupancy
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_PC = 32'h0000_3000,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      restart_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [5:0]                in_id_i,
  input  logic [4:0]                in_rs_i,
  input  logic [4:0]                in_rt_i,
  input  logic [4:0]                in_rd_i,
  input  logic [4:0]                in_shamt_i,
  input  logic [15:0]               in_imm16_i,
  input  logic [31:0]               in_target_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [31:0]               out_instr_o,
  output logic [31:0]               out_pc_o,
  output logic                      out_err_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  // Opcodes
  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2b;

  // REGIMM rt selectors
  localparam logic [4:0] RtBltz   = 5'h00;
  localparam logic [4:0] RtBgez   = 5'h01;
  localparam logic [4:0] RtBltzal = 5'h10;

  // Mnemonic ids that are referenced individually
  localparam logic [5:0] IdJr     = 6'd24;
  localparam logic [5:0] IdJalr   = 6'd25;
  localparam logic [5:0] IdBeq    = 6'd34;
  localparam logic [5:0] IdBne    = 6'd35;
  localparam logic [5:0] IdBlez   = 6'd36;
  localparam logic [5:0] IdBgtz   = 6'd37;
  localparam logic [5:0] IdBltz   = 6'd38;
  localparam logic [5:0] IdBgez   = 6'd39;
  localparam logic [5:0] IdBltzal = 6'd40;
  localparam logic [5:0] IdJ      = 6'd41;
  localparam logic [5:0] IdJal    = 6'd42;

  // SPECIAL funct field for ids 0..25; other ids return 0.
  function automatic logic [5:0] rFunct(input logic [5:0] id);
    logic [5:0] fn;
    fn = 6'h00;
    case (id)
      6'd0:    fn = 6'h20; // add
      6'd1:    fn = 6'h21; // addu
      6'd2:    fn = 6'h22; // sub
      6'd3:    fn = 6'h23; // subu
      6'd4:    fn = 6'h24; // and
      6'd5:    fn = 6'h25; // or
      6'd6:    fn = 6'h26; // xor
      6'd7:    fn = 6'h27; // nor
      6'd8:    fn = 6'h2a; // slt
      6'd9:    fn = 6'h2b; // sltu
      6'd10:   fn = 6'h00; // sll
      6'd11:   fn = 6'h02; // srl
      6'd12:   fn = 6'h03; // sra
      6'd13:   fn = 6'h04; // sllv
      6'd14:   fn = 6'h06; // srlv
      6'd15:   fn = 6'h07; // srav
      6'd16:   fn = 6'h18; // mult
      6'd17:   fn = 6'h19; // multu
      6'd18:   fn = 6'h1a; // div
      6'd19:   fn = 6'h1b; // divu
      6'd20:   fn = 6'h10; // mfhi
      6'd21:   fn = 6'h12; // mflo
      6'd22:   fn = 6'h11; // mthi
      6'd23:   fn = 6'h13; // mtlo
      6'd24:   fn = 6'h08; // jr
      6'd25:   fn = 6'h09; // jalr
      default: fn = 6'h00;
    endcase
    return fn;
  endfunction

  // Primary opcode for the non-SPECIAL, non-REGIMM ids.
  function automatic logic [5:0] primaryOp(input logic [5:0] id);
    logic [5:0] op;
    op = OpSpecial;
    case (id)
      6'd26:   op = OpLb;
      6'd27:   op = OpLh;
      6'd28:   op = OpLw;
      6'd29:   op = OpLbu;
      6'd30:   op = OpLhu;
      6'd31:   op = OpSb;
      6'd32:   op = OpSh;
      6'd33:   op = OpSw;
      IdBeq:   op = OpBeq;
      IdBne:   op = OpBne;
      IdBlez:  op = OpBlez;
      IdBgtz:  op = OpBgtz;
      IdJ:     op = OpJ;
      IdJal:   op = OpJal;
      6'd43:   op = OpAddi;
      6'd44:   op = OpAddiu;
      6'd45:   op = OpAndi;
      6'd46:   op = OpOri;
      6'd47:   op = OpXori;
      default: op = OpSpecial;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] rWord(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {OpSpecial, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] iWord(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jWord(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // State
  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW:0]   count_q, count_d;

  logic [31:0] instrMem_q [DEPTH];
  logic [31:0] pcMem_q    [DEPTH];
  logic        errMem_q   [DEPTH];

  logic        push;
  logic        pop;
  logic        full;

  logic [31:0]        pcPlus4;
  logic signed [31:0] brDiff;
  logic signed [31:0] brShift;
  logic               brErr;
  logic               jmpErr;
  logic [31:0]        encWord;
  logic               encErr;

  assign full       = (count_q == FullCount);
  assign in_ready_o = !full && !restart_i;
  assign push       = in_valid_i && in_ready_o;
  // Restart wins over a pop in the same cycle.
  assign pop        = out_valid_o && out_ready_i && !restart_i;

  assign pcPlus4 = pc_q + 32'd4;

  // Branch offset is measured from the delay-slot address; it is only
  // representable if bits [31:15] of the shifted difference are a pure
  // sign extension of bit 15.
  assign brDiff  = $signed(in_target_i - pcPlus4);
  assign brShift = brDiff >>> 2;
  assign brErr   = (in_target_i[1:0] != 2'b00)
                 || !((brShift[31:15] == '0) || (brShift[31:15] == '1));
  assign jmpErr  = (in_target_i[1:0] != 2'b00)
                 || (in_target_i[31:28] != pcPlus4[31:28]);

  // Encoder: unused fields are forced to zero; illegal ids give a zero word.
  always_comb begin
    encWord = '0;
    encErr  = 1'b0;
    case (in_id_i) inside
      [6'd0:6'd9], [6'd13:6'd15]:
        encWord = rWord(in_rs_i, in_rt_i, in_rd_i, 5'd0, rFunct(in_id_i));
      [6'd10:6'd12]:
        encWord = rWord(5'd0, in_rt_i, in_rd_i, in_shamt_i, rFunct(in_id_i));
      [6'd16:6'd19]:
        encWord = rWord(in_rs_i, in_rt_i, 5'd0, 5'd0, rFunct(in_id_i));
      6'd20, 6'd21:
        encWord = rWord(5'd0, 5'd0, in_rd_i, 5'd0, rFunct(in_id_i));
      6'd22, 6'd23, IdJr:
        encWord = rWord(in_rs_i, 5'd0, 5'd0, 5'd0, rFunct(in_id_i));
      IdJalr:
        encWord = rWord(in_rs_i, 5'd0, in_rd_i, 5'd0, rFunct(in_id_i));
      [6'd26:6'd33], [6'd43:6'd47]:
        encWord = iWord(primaryOp(in_id_i), in_rs_i, in_rt_i, in_imm16_i);
      IdBeq, IdBne: begin
        encWord = iWord(primaryOp(in_id_i), in_rs_i, in_rt_i, brShift[15:0]);
        encErr  = brErr;
      end
      IdBlez, IdBgtz: begin
        encWord = iWord(primaryOp(in_id_i), in_rs_i, 5'd0, brShift[15:0]);
        encErr  = brErr;
      end
      IdBltz: begin
        encWord = iWord(OpRegimm, in_rs_i, RtBltz, brShift[15:0]);
        encErr  = brErr;
      end
      IdBgez: begin
        encWord = iWord(OpRegimm, in_rs_i, RtBgez, brShift[15:0]);
        encErr  = brErr;
      end
      IdBltzal: begin
        encWord = iWord(OpRegimm, in_rs_i, RtBltzal, brShift[15:0]);
        encErr  = brErr;
      end
      IdJ, IdJal: begin
        encWord = jWord(primaryOp(in_id_i), in_target_i[27:2]);
        encErr  = jmpErr;
      end
      default: begin
        encWord = '0;
        encErr  = 1'b1;
      end
    endcase
  end

  // Pointer, occupancy and address-counter next state. Restart clears the
  // queue and reloads the counter regardless of push/pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    pc_d    = pc_q;
    if (restart_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      pc_d    = BASE_PC;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PtrW'(1);
        pc_d    = pcPlus4;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      pc_q    <= BASE_PC;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

  // Storage needs no reset: an entry is only visible while count_q covers it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instrMem_q[wrPtr_q] <= encWord;
      pcMem_q[wrPtr_q]    <= pc_q;
      errMem_q[wrPtr_q]   <= encErr;
    end
  end

  // Head fields read as zero while the queue is empty.
  assign out_valid_o = (count_q != '0);
  assign out_instr_o = out_valid_o ? instrMem_q[rdPtr_q] : 32'd0;
  assign out_pc_o    = out_valid_o ? pcMem_q[rdPtr_q]    : 32'd0;
  assign out_err_o   = out_valid_o ? errMem_q[rdPtr_q]   : 1'b0;
  assign count_o     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: hand-computed words, addresses and
// error flags, plus backpressure, restart and mid-stream reset sequences.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        restart;
  logic        inValid;
  logic        inReady;
  logic [5:0]  inId;
  logic [4:0]  inRs;
  logic [4:0]  inRt;
  logic [4:0]  inRd;
  logic [4:0]  inShamt;
  logic [15:0] inImm16;
  logic [31:0] inTarget;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic [31:0] outPc;
  logic        outErr;
  logic [2:0]  count;

  int          totalChecks = 0;
  int          badChecks   = 0;
  logic [31:0] expPc;

  // Backpressure words: addu rs=1 rt=2 rd=1..5
  logic [31:0] bpWords [5] = '{32'h0022_0821, 32'h0022_1021, 32'h0022_1821,
                               32'h0022_2021, 32'h0022_2821};

  always #5 clk = ~clk;

  instr_encoder #(
    .BASE_PC(32'h0000_3000),
    .DEPTH  (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .restart_i  (restart),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .in_id_i    (inId),
    .in_rs_i    (inRs),
    .in_rt_i    (inRt),
    .in_rd_i    (inRd),
    .in_shamt_i (inShamt),
    .in_imm16_i (inImm16),
    .in_target_i(inTarget),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .out_instr_o(outInstr),
    .out_pc_o   (outPc),
    .out_err_o  (outErr),
    .count_o    (count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge after accept.
  task automatic applyStimulus(input logic [5:0] id, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh,
                               input logic [15:0] imm, input logic [31:0] tgt);
    int waited = 0;
    inId     = id;
    inRs     = rs;
    inRt     = rt;
    inRd     = rd;
    inShamt  = sh;
    inImm16  = imm;
    inTarget = tgt;
    inValid  = 1'b1;
    #1;
    while (!inReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!inReady) begin
      checkOutput("acceptTimeout", 32'(inReady), 32'd1);
      inValid = 1'b0;
      return;
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic popHead();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  // Push into an empty queue, check the head against expectations, then drain it.
  task automatic runVector(input string tag, input logic [5:0] id, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [31:0] tgt,
                           input logic [31:0] expInstr, input logic expErr);
    applyStimulus(id, rs, rt, rd, sh, imm, tgt);
    checkOutput({tag, "_instr"}, outInstr, expInstr);
    checkOutput({tag, "_pc"}, outPc, expPc);
    checkOutput({tag, "_err"}, 32'(outErr), 32'(expErr));
    popHead();
    expPc = expPc + 32'd4;
  endtask

  initial begin
    rstN     = 1'b0;
    restart  = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    inId     = '0;
    inRs     = '0;
    inRt     = '0;
    inRd     = '0;
    inShamt  = '0;
    inImm16  = '0;
    inTarget = '0;

    repeat (2) @(negedge clk);
    checkOutput("resetCount", 32'(count), 32'd0);
    checkOutput("resetValid", 32'(outValid), 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("resetReady", 32'(inReady), 32'd1);
    checkOutput("resetInstr", outInstr, 32'd0);
    checkOutput("resetPc", outPc, 32'd0);
    checkOutput("resetErr", 32'(outErr), 32'd0);

    // addu stays queued so the following beq lands at 0x3004
    applyStimulus(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0);
    checkOutput("addu_instr", outInstr, 32'h0022_1821);
    checkOutput("addu_pc", outPc, 32'h0000_3000);
    checkOutput("addu_err", 32'(outErr), 32'd0);
    applyStimulus(6'd34, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h0000_3000);
    checkOutput("twoQueued_count", 32'(count), 32'd2);
    checkOutput("holdHead_instr", outInstr, 32'h0022_1821);
    popHead();
    checkOutput("beqBack_instr", outInstr, 32'h1022_FFFE);
    checkOutput("beqBack_pc", outPc, 32'h0000_3004);
    checkOutput("beqBack_err", 32'(outErr), 32'd0);
    popHead();
    expPc = 32'h0000_3008;

    // pc=0x3008: (0x3002-0x300C)>>>2 = -3, misaligned target
    runVector("beqMisalign", 6'd34, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h0000_3002, 32'h1022_FFFD, 1'b1);
    runVector("jal", 6'd42, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0000_3010, 32'h0C00_0C04, 1'b0);
    runVector("ori", 6'd46, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234, 32'h0, 32'h3405_1234, 1'b0);
    // pc=0x3014, target=pc+4 -> offset 0, rt=0x10
    runVector("bltzal", 6'd40, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0000_3018, 32'h0490_0000, 1'b0);
    runVector("illegal", 6'd63, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 32'h0, 32'h0000_0000, 1'b1);
    runVector("sll", 6'd10, 5'd0, 5'd2, 5'd3, 5'd4, 16'h0, 32'h0, 32'h0002_1900, 1'b0);
    // pc=0x3020: target in another 256MB region
    runVector("jRegion", 6'd41, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0000, 32'h0800_0000, 1'b1);
    // pc=0x3024: offset +32768 overflows
    runVector("beqOver", 6'd34, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h0002_3028, 32'h1022_8000, 1'b1);
    // pc=0x3028: offset +32767 fits
    runVector("beqMax", 6'd34, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h0002_3028, 32'h1022_7FFF, 1'b0);
    runVector("mfhi", 6'd20, 5'd7, 5'd8, 5'd5, 5'd0, 16'h0, 32'h0, 32'h0000_2810, 1'b0);
    runVector("lw", 6'd28, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 32'h0, 32'h8FA8_FFFC, 1'b0);

    // Restart on an empty queue reloads the address counter
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checkOutput("restartEmpty_count", 32'(count), 32'd0);
    expPc = 32'h0000_3000;

    // Backpressure: four accepts fill the queue, the fifth is held
    for (int k = 0; k < 4; k++) begin
      applyStimulus(6'd1, 5'd1, 5'd2, 5'(k + 1), 5'd0, 16'h0, 32'h0);
    end
    checkOutput("bpFull_count", 32'(count), 32'd4);
    checkOutput("bpFull_ready", 32'(inReady), 32'd0);
    inId    = 6'd1;
    inRs    = 5'd1;
    inRt    = 5'd2;
    inRd    = 5'd5;
    inValid = 1'b1;
    @(negedge clk);
    checkOutput("bpHeld_count", 32'(count), 32'd4);
    checkOutput("bpHeld_ready", 32'(inReady), 32'd0);
    checkOutput("bpHead0_instr", outInstr, bpWords[0]);
    checkOutput("bpHead0_pc", outPc, 32'h0000_3000);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("bpAfterPop_count", 32'(count), 32'd3);
    checkOutput("bpAfterPop_ready", 32'(inReady), 32'd1);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("bpFifth_count", 32'(count), 32'd4);
    for (int k = 1; k < 5; k++) begin
      checkOutput($sformatf("bpDrain%0d_instr", k), outInstr, bpWords[k]);
      checkOutput($sformatf("bpDrain%0d_pc", k), outPc, 32'h0000_3000 + 32'(4 * k));
      popHead();
    end
    checkOutput("bpEmpty_valid", 32'(outValid), 32'd0);
    checkOutput("bpEmpty_instr", outInstr, 32'd0);

    // Restart with three queued and a request pending
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'd1, 5'd1, 5'd2, 5'(k + 1), 5'd0, 16'h0, 32'h0);
    end
    checkOutput("preRestart_count", 32'(count), 32'd3);
    inId    = 6'd46;
    inValid = 1'b1;
    restart = 1'b1;
    #1;
    checkOutput("restartReady", 32'(inReady), 32'd0);
    @(negedge clk);
    restart = 1'b0;
    inValid = 1'b0;
    checkOutput("restart_count", 32'(count), 32'd0);
    checkOutput("restart_valid", 32'(outValid), 32'd0);
    expPc = 32'h0000_3000;
    runVector("postRestart", 6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 32'h0022_1821, 1'b0);

    // Asynchronous reset while draining
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'd1, 5'd1, 5'd2, 5'(k + 1), 5'd0, 16'h0, 32'h0);
    end
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("midDrain_count", 32'(count), 32'd2);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncReset_valid", 32'(outValid), 32'd0);
    checkOutput("asyncReset_count", 32'(count), 32'd0);
    checkOutput("asyncReset_instr", outInstr, 32'd0);
    checkOutput("asyncReset_pc", outPc, 32'd0);
    outReady = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    expPc = 32'h0000_3000;
    runVector("postReset", 6'd46, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234, 32'h0, 32'h3405_1234, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
